sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//   Downstream stage of the 32-bit adder. Takes each adder sum as a signed
//   two's-complement sample over a valid/ready handshake. Adds NUM_SAMPLES
//   samples into a wide register, then presents the frame total with a
//   sample count and an overflow flag over a second valid/ready handshake.
// PARAMETERS
//   WIDTH        32  input sample width (matches adder sum width)
//   ACC_WIDTH    40  accumulator/result width; must be >= WIDTH
//   NUM_SAMPLES  4   samples per frame; must be >= 1
// PORTS
//   clk        in   1                      single clock, rising edge
//   rst        in   1                      synchronous, active-high reset
//   in_valid   in   1                      in_sum carries a sample
//   in_ready   out  1                      block can accept a sample
//   in_sum     in   WIDTH                  signed sample from adder
//   clear      in   1                      synchronous frame abort
//   out_valid  out  1                      out_* carry a finished frame
//   out_ready  in   1                      consumer accepts the frame
//   out_acc    out  ACC_WIDTH              signed frame total
//   out_count  out  $clog2(NUM_SAMPLES+1)  samples in the frame
//   out_ovf    out  1                      sticky overflow/saturation flag
// BEHAVIOUR
//   - Clock and reset: one clock, clk; reset is synchronous and active-high
//     on rst. While rst=1: state=ACC, acc=0, count=0, ovf=0, out_valid=0,
//     out_acc=0, out_count=0, out_ovf=0. The block drives in_ready=1 in the
//     first cycle after rst is released.
//   - FSM with 2 states, ACC and DONE. in_ready = (state==ACC). out_valid =
//     (state==DONE). Both are decoded from registered state only; no
//     combinational path from inputs.
//   - ACC: an input transfer occurs when in_valid && in_ready. On transfer:
//     * in_sum is sign-extended to ACC_WIDTH and added to acc.
//     * count increments.
//     * ovf |= signed overflow of that add.
//   - Last sample: if the transfer makes count == NUM_SAMPLES:
//     * out_acc, out_count and out_ovf load the new values.
//     * acc, count and ovf clear.
//     * state goes to DONE.
//     * Latency: out_valid=1 in the cycle after the last sample transfer.
//   - DONE: out_* hold stable. in_sum is ignored even when in_valid=1.
//     On out_valid && out_ready, the next state is ACC; no bubble beyond
//     that one edge.
//   - clear=1 has priority over any input or output transfer in the same
//     cycle. The next state is ACC with acc, count, ovf and out_valid all
//     0. A sample offered in that cycle is dropped. out_acc, out_count and
//     out_ovf keep their last values. clear is ignored while rst=1.
//   - Mid-frame rst behaves exactly like clear, and also zeroes the out_*
//     registers.
//   - NUM_SAMPLES=1: every accepted sample produces a frame. Throughput is
//     1 sample per 2 cycles.
//   - Wrap: without the macro below, additions wrap modulo 2^ACC_WIDTH.
// CONFIGURATION
//   SUM_ACC_SAT_EN defined:
//     * An overflowing add clamps acc to +(2^(ACC_WIDTH-1)-1) or
//       -2^(ACC_WIDTH-1), matching the overflow direction.
//     * Later samples in the frame add from the clamped value.
//     * out_ovf is still set.
//   SUM_ACC_SAT_EN undefined: wrapping arithmetic; out_ovf is the only
//     indication of overflow.
// TESTING
//   1. Defaults; feed 10,20,30,40 back to back, out_ready=1 -> out_acc=100,
//      out_count=4, out_ovf=0. out_valid is high for exactly 1 cycle, one
//      cycle after the 40 transfer.
//   2. Feed -5,15,-1234,4321 -> out_acc=3097. Check the sign extension in
//      the upper 8 bits of a negative interim acc (e.g. 0xFFFFFFFFFB after
//      -5).
//   3. Hold out_ready=0 for 5 cycles after a frame -> out_valid and out_acc
//      stable, in_ready=0, offered samples not accepted. Raise out_ready ->
//      in_ready=1 on the next cycle.
//   4. ACC_WIDTH=32, NUM_SAMPLES=2; feed 0x7FFFFFFF then 1 -> out_acc=
//      0x80000000, out_ovf=1 (macro off). With SUM_ACC_SAT_EN -> out_acc=
//      0x7FFFFFFF, out_ovf=1.
//   5. Feed 10,20, then assert clear together with a valid sample 30. Then
//      feed 1,2,3,4 -> out_acc=10, out_count=4; 30 is dropped.
//   6. Assert rst for 1 cycle in DONE and again mid-frame -> all outputs 0,
//      in_ready=1 the next cycle. The next 4-sample frame sums correctly.

Source files
------------

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums NUM_SAMPLES signed samples and returns the total, the sample count and a sticky overflow flag.
// Optional saturating arithmetic is enabled with `define SUM_ACC_SAT_EN; the default build wraps.
module sum_accumulator #(
  parameter int WIDTH       = 32,
  parameter int ACC_WIDTH   = 40,
  parameter int NUM_SAMPLES = 4,
  localparam int CW         = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CW-1:0]        out_count,
  output logic                 out_ovf
);

  typedef enum logic {ACC, DONE} state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CW-1:0]          count;
  logic                   ovf;

  logic [ACC_WIDTH-1:0]   ext;
  logic [ACC_WIDTH-1:0]   sum_raw;
  logic [ACC_WIDTH-1:0]   sum_next;
  logic                   add_ovf;
  logic [CW-1:0]          count_next;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);

  always_comb begin
    ext        = ACC_WIDTH'($signed(in_sum));
    sum_raw    = acc + ext;
    // Signed overflow: operands share a sign that the result does not.
    add_ovf    = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                 (sum_raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    count_next = count + CW'(1);
    sum_next   = sum_raw;
`ifdef SUM_ACC_SAT_EN
    if (add_ovf) begin
      sum_next = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      state <= ACC;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (count_next == CW'(NUM_SAMPLES)) begin
              out_acc   <= sum_next;
              out_count <= count_next;
              out_ovf   <= ovf | add_ovf;
              acc       <= '0;
              count     <= '0;
              ovf       <= 1'b0;
              state     <= DONE;
            end else begin
              acc   <= sum_next;
              count <= count_next;
              ovf   <= ovf | add_ovf;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance plus a 32-bit, 2-sample instance for overflow cases.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic        in_valid, in_ready, clear, out_valid, out_ready, out_ovf;
  logic [31:0] in_sum;
  logic [39:0] out_acc;
  logic [2:0]  out_count;

  // ACC_WIDTH=32, NUM_SAMPLES=2 instance
  logic        in_valid2, in_ready2, clear2, out_valid2, out_ready2, out_ovf2;
  logic [31:0] in_sum2;
  logic [31:0] out_acc2;
  logic [1:0]  out_count2;

  int n_checks = 0;
  int n_fail   = 0;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  sum_accumulator #(.WIDTH(32), .ACC_WIDTH(32), .NUM_SAMPLES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_sum(in_sum2),
    .clear(clear2), .out_valid(out_valid2), .out_ready(out_ready2), .out_acc(out_acc2),
    .out_count(out_count2), .out_ovf(out_ovf2)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one sample across exactly one rising edge; returns at the following falling edge.
  task automatic feed_one(input logic [31:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic feed2_one(input logic [31:0] v);
    in_valid2 = 1'b1;
    in_sum2   = v;
    @(negedge clk);
    in_valid2 = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [39:0] acc_exp, input logic ovf_exp);
    check_val({tag, "_vld"},   64'(out_valid), 64'd1);
    check_val({tag, "_acc"},   64'(out_acc),   64'(acc_exp));
    check_val({tag, "_count"}, 64'(out_count), 64'd4);
    check_val({tag, "_ovf"},   64'(out_ovf),   64'(ovf_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_pos, exp_neg;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; clear = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_sum2 = '0; clear2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_acc",   64'(out_acc),   64'd0);
    check_val("rst_out_count", 64'(out_count), 64'd0);
    check_val("rst_out_ovf",   64'(out_ovf),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back frame, one-cycle result pulse
    feed_one(32'd10); feed_one(32'd20); feed_one(32'd30); feed_one(32'd40);
    check_frame("t1", 40'd100, 1'b0);
    check_val("t1_in_ready_done", 64'(in_ready), 64'd0);
    @(negedge clk);
    check_val("t1_vld_pulse", 64'(out_valid), 64'd0);
    check_val("t1_in_ready_back", 64'(in_ready), 64'd1);

    // Mixed signs and sign extension of interim accumulator
    feed_one(-32'sd5);
    check_val("t2_interim_sext", 64'(dut.acc), 64'h00_0000_00FF_FFFF_FFFB);
    feed_one(32'd15); feed_one(-32'sd1234); feed_one(32'd4321);
    check_frame("t2", 40'd3097, 1'b0);
    @(negedge clk);
    feed_one(-32'sd5); feed_one(-32'sd1); feed_one(-32'sd1); feed_one(-32'sd1);
    check_frame("t2_neg", 40'hFF_FFFF_FFF8, 1'b0);
    @(negedge clk);

    // Output backpressure: DONE holds and refuses samples
    out_ready = 1'b0;
    feed_one(32'd1); feed_one(32'd1); feed_one(32'd1); feed_one(32'd1);
    check_frame("t3", 40'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sum = 32'd999;
      @(negedge clk);
      check_val("t3_hold_vld", 64'(out_valid), 64'd1);
      check_val("t3_hold_acc", 64'(out_acc),   64'd4);
      check_val("t3_hold_rdy", 64'(in_ready),  64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_val("t3_release_vld", 64'(out_valid), 64'd0);
    check_val("t3_release_rdy", 64'(in_ready),  64'd1);
    feed_one(32'd5); feed_one(32'd6); feed_one(32'd7); feed_one(32'd8);
    check_frame("t3_next", 40'd26, 1'b0);
    @(negedge clk);

    // 32-bit accumulator overflow, both directions
`ifdef SUM_ACC_SAT_EN
    exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h8000_0000; exp_neg = 32'h7FFF_FFFF;
`endif
    feed2_one(32'h7FFF_FFFF); feed2_one(32'd1);
    check_val("t4_pos_vld",   64'(out_valid2), 64'd1);
    check_val("t4_pos_acc",   64'(out_acc2),   64'(exp_pos));
    check_val("t4_pos_ovf",   64'(out_ovf2),   64'd1);
    check_val("t4_pos_count", 64'(out_count2), 64'd2);
    @(negedge clk);
    feed2_one(32'h8000_0000); feed2_one(32'hFFFF_FFFF);
    check_val("t4_neg_acc", 64'(out_acc2), 64'(exp_neg));
    check_val("t4_neg_ovf", 64'(out_ovf2), 64'd1);
    @(negedge clk);
    feed2_one(32'd3); feed2_one(32'd4);
    check_val("t4_ovf_cleared", 64'(out_ovf2), 64'd0);
    check_val("t4_small_acc",   64'(out_acc2), 64'd7);

    // clear drops the offered sample and the partial frame
    feed_one(32'd10); feed_one(32'd20);
    clear = 1'b1; in_valid = 1'b1; in_sum = 32'd30;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check_val("t5_clr_vld",   64'(out_valid), 64'd0);
    check_val("t5_clr_rdy",   64'(in_ready),  64'd1);
    check_val("t5_clr_keep",  64'(out_acc),   64'd26);
    feed_one(32'd1); feed_one(32'd2); feed_one(32'd3); feed_one(32'd4);
    check_frame("t5", 40'd10, 1'b0);
    @(negedge clk);

    // Reset in DONE and mid-frame
    out_ready = 1'b0;
    feed_one(32'd9); feed_one(32'd9); feed_one(32'd9); feed_one(32'd9);
    check_val("t6_done_vld", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    check_val("t6_rst_vld",   64'(out_valid), 64'd0);
    check_val("t6_rst_acc",   64'(out_acc),   64'd0);
    check_val("t6_rst_count", 64'(out_count), 64'd0);
    @(negedge clk);
    check_val("t6_rst_rdy",   64'(in_ready),  64'd1);
    feed_one(32'd7); feed_one(32'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("t6_mid_rdy", 64'(in_ready), 64'd1);
    check_val("t6_mid_ovf", 64'(out_ovf),  64'd0);
    feed_one(32'd1); feed_one(32'd2); feed_one(32'd3); feed_one(32'd4);
    check_frame("t6", 40'd10, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
